// File: rtl/jtpang_pkg.sv
// Shared types and constants for the Pang object DMA controller.
package jtpang_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAITVB,
    REQ,
    COPY,
    REL
  } dma_state_t;

  localparam int          OBJ_LEN      = 512;
  localparam logic [11:0] OBJ_SRC_BASE = 12'h000;

endpackage

// File: rtl/jtpang_objdma.sv
// Object DMA: on a dma_go edge, waits for VBLANK, takes the Z80 bus and
// copies the object table from video RAM into the object line buffer.
module jtpang_objdma
  import jtpang_pkg::*;
#(
  parameter int            AW       = 12,
  parameter logic [AW-1:0] SRC_BASE = AW'(OBJ_SRC_BASE),
  parameter int            LEN      = OBJ_LEN,
  parameter int            OAW      = 9
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cen,
  input  logic           dma_go,
  input  logic           LVBL,
  input  logic           busak_n,
  output logic           busrq_n,
  output logic [AW-1:0]  src_addr,
  output logic           src_cs,
  input  logic [7:0]     src_din,
  output logic [OAW-1:0] obj_addr,
  output logic           obj_we,
  output logic [7:0]     obj_dout,
  output logic           busy
);

  localparam int            KW    = OAW + 1;
  localparam logic [KW-1:0] LEN_K = KW'(LEN);

  dma_state_t     state_reg, state_next;
  logic           go_d_reg;
  logic           pending_reg, pending_next;
  logic           busy_reg, busy_next;
  logic           busrq_reg, busrq_next;
  logic [KW-1:0]  k_reg, k_next;
  logic           reread_reg, reread_next;
  logic [AW-1:0]  src_addr_reg, src_addr_next;
  logic           src_cs_reg, src_cs_next;
  logic [OAW-1:0] obj_addr_reg, obj_addr_next;
  logic [7:0]     obj_dout_reg, obj_dout_next;
  logic           obj_we_reg, obj_we_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      go_d_reg     <= 1'b0;
      pending_reg  <= 1'b0;
      busy_reg     <= 1'b0;
      busrq_reg    <= 1'b1;
      k_reg        <= '0;
      reread_reg   <= 1'b0;
      src_addr_reg <= SRC_BASE;
      src_cs_reg   <= 1'b0;
      obj_addr_reg <= '0;
      obj_dout_reg <= '0;
      obj_we_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      go_d_reg     <= dma_go;
      pending_reg  <= pending_next;
      busy_reg     <= busy_next;
      busrq_reg    <= busrq_next;
      k_reg        <= k_next;
      reread_reg   <= reread_next;
      src_addr_reg <= src_addr_next;
      src_cs_reg   <= src_cs_next;
      obj_addr_reg <= obj_addr_next;
      obj_dout_reg <= obj_dout_next;
      obj_we_reg   <= obj_we_next;
    end
  end

  // The trigger edge is caught on every clk; only one request is ever queued.
  always_comb begin
    state_next    = state_reg;
    pending_next  = pending_reg | (dma_go & ~go_d_reg);
    busy_next     = busy_reg;
    busrq_next    = busrq_reg;
    k_next        = k_reg;
    reread_next   = reread_reg;
    src_addr_next = src_addr_reg;
    src_cs_next   = src_cs_reg;
    obj_addr_next = obj_addr_reg;
    obj_dout_next = obj_dout_reg;
    obj_we_next   = 1'b0;
    if (cen) begin
      unique case (state_reg)
        IDLE: begin
          if (pending_reg) begin
            pending_next = 1'b0;
            busy_next    = 1'b1;
            state_next   = WAITVB;
          end
        end
        WAITVB: begin
          if (!LVBL) begin
            busrq_next = 1'b0;
            state_next = REQ;
          end
        end
        REQ: begin
          busrq_next = 1'b0;
          if (!busak_n) begin
            k_next      = '0;
            reread_next = 1'b0;
            state_next  = COPY;
          end
        end
        COPY: begin
          if (busak_n) begin
            // CPU took the bus back: the byte in flight must be fetched again.
            if (k_reg != '0) reread_next = 1'b1;
          end else if (reread_reg) begin
            src_addr_next = SRC_BASE + AW'(k_reg - KW'(1));
            src_cs_next   = 1'b1;
            reread_next   = 1'b0;
          end else begin
            if (k_reg < LEN_K) begin
              src_addr_next = SRC_BASE + AW'(k_reg);
              src_cs_next   = 1'b1;
            end else begin
              src_cs_next = 1'b0;
            end
            if (k_reg != '0) begin
              obj_we_next   = 1'b1;
              obj_addr_next = OAW'(k_reg - KW'(1));
              obj_dout_next = src_din;
            end
            if (k_reg == LEN_K) begin
              busrq_next = 1'b1;
              state_next = REL;
            end else begin
              k_next = k_reg + KW'(1);
            end
          end
        end
        REL: begin
          busrq_next  = 1'b1;
          src_cs_next = 1'b0;
          if (busak_n) begin
            busy_next  = 1'b0;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign busrq_n  = busrq_reg;
  assign src_addr = src_addr_reg;
  assign src_cs   = src_cs_reg;
  assign obj_addr = obj_addr_reg;
  assign obj_dout = obj_dout_reg;
  assign obj_we   = obj_we_reg;
  assign busy     = busy_reg;

endmodule

// File: tb/tb_jtpang_objdma.sv
// Directed bench for jtpang_objdma with a bus-ack model and a source RAM model.
module tb_jtpang_objdma;

  localparam logic [11:0] SB = 12'hF00;
  localparam int          N  = 512;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cen = 1'b0;
  logic        dma_go = 1'b0;
  logic        LVBL = 1'b1;
  logic        busak_n;
  logic        busrq_n;
  logic [11:0] src_addr;
  logic        src_cs;
  logic [7:0]  src_din = 8'h00;
  logic [8:0]  obj_addr;
  logic        obj_we;
  logic [7:0]  obj_dout;
  logic        busy;

  jtpang_objdma #(.AW(12), .SRC_BASE(SB), .LEN(N), .OAW(9)) dut (
    .clk(clk), .rst(rst), .cen(cen), .dma_go(dma_go), .LVBL(LVBL),
    .busak_n(busak_n), .busrq_n(busrq_n), .src_addr(src_addr), .src_cs(src_cs),
    .src_din(src_din), .obj_addr(obj_addr), .obj_we(obj_we), .obj_dout(obj_dout),
    .busy(busy)
  );

  always #5 clk = ~clk;
  initial forever begin
    @(negedge clk);
    cen = ~cen;
  end

  // CPU bus-ack model: follows busrq_n after ak_delay cen, or forced high.
  int         ak_delay = 0;
  logic       ak_force = 1'b0;
  logic [7:0] rq_hist = 8'hFF;
  always @(posedge clk) if (cen) rq_hist <= {rq_hist[6:0], busrq_n};
  always_comb busak_n = ak_force | ((ak_delay == 0) ? busrq_n : rq_hist[3'(ak_delay - 1)]);

  // Source RAM answers between cen edges; garbage while the CPU owns the bus.
  logic [7:0] src_mem [4096];
  always @(posedge clk) if (!cen) src_din <= busak_n ? 8'hEE : src_mem[src_addr];

  logic [7:0]  obj_buf [N];
  int          hits [N];
  int          wr_cnt = 0, order_err = 0, gap_wr = 0, busy_rises = 0, own_cnt = 0;
  logic        in_gap = 1'b0, busy_q = 1'b0, wrap_seen = 1'b0;
  logic [8:0]  last_addr = '0;
  logic [11:0] prev_src = '0;

  always @(negedge clk) begin
    if (obj_we) begin
      wr_cnt <= wr_cnt + 1;
      hits[obj_addr] <= hits[obj_addr] + 1;
      obj_buf[obj_addr] <= obj_dout;
      if (obj_addr != 9'd0 && obj_addr != last_addr + 9'd1) order_err <= order_err + 1;
      if (in_gap) gap_wr <= gap_wr + 1;
      last_addr <= obj_addr;
    end
    if (busy && !busy_q) busy_rises <= busy_rises + 1;
    busy_q <= busy;
    if (src_cs) begin
      if (prev_src == 12'hFFF && src_addr == 12'h000) wrap_seen <= 1'b1;
      prev_src <= src_addr;
    end
  end

  always @(posedge clk) if (cen && !busak_n && !rst) own_cnt <= own_cnt + 1;

  int checks = 0, failures = 0;
  int wr_b, ord_b, gap_b, own_b, rise_b;
  int hits_b [N];
  int lows = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cen();
    do @(posedge clk); while (!cen);
    #1;
  endtask

  task automatic pulse_go();
    dma_go = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    dma_go = 1'b0;
  endtask

  task automatic snap();
    wr_b = wr_cnt; ord_b = order_err; gap_b = gap_wr; own_b = own_cnt; rise_b = busy_rises;
    for (int a = 0; a < N; a++) hits_b[a] = hits[a];
  endtask

  task automatic fill_src(input int seed);
    for (int a = 0; a < 4096; a++) src_mem[a] = 8'(a * 3 + (a >> 8) + seed * 41);
  endtask

  task automatic wait_busy(input string tag, input logic lvl, input int budget);
    int n = 0;
    while (busy !== lvl && n < budget) begin
      wait_cen();
      n++;
    end
    check_val(tag, busy, lvl);
  endtask

  task automatic wait_writes(input string tag, input int target, input int budget);
    int n = 0;
    while (wr_cnt - wr_b < target && n < budget) begin
      wait_cen();
      n++;
    end
    check_val(tag, (wr_cnt - wr_b) >= target, 1);
  endtask

  task automatic check_xfer(input string tag, input int reps);
    int errs = 0;
    logic [11:0] sa;
    check_val({tag, "_writes"}, wr_cnt - wr_b, N * reps);
    for (int a = 0; a < N; a++) begin
      sa = SB + 12'(a);
      if (hits[a] - hits_b[a] != reps) errs++;
      if (obj_buf[a] !== src_mem[sa]) errs++;
    end
    check_val({tag, "_data"}, errs, 0);
    check_val({tag, "_order"}, order_err - ord_b, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fill_src(1);
    repeat (4) @(posedge clk);
    #1;
    check_val("rst_busrq_n", busrq_n, 1);
    check_val("rst_busy", busy, 0);
    check_val("rst_src_cs", src_cs, 0);
    check_val("rst_obj_we", obj_we, 0);
    check_val("rst_src_addr", src_addr, SB);
    check_val("rst_obj_addr", obj_addr, 0);
    check_val("rst_obj_dout", obj_dout, 0);
    @(negedge clk);
    rst = 1'b0;

    // Trigger in active video; bus granted 3 cen after the request.
    ak_delay = 3;
    snap();
    pulse_go();
    for (int i = 0; i < 100; i++) begin
      wait_cen();
      if (!busrq_n) lows++;
    end
    check_val("t1_no_req_active", lows, 0);
    check_val("t1_busy", busy, 1);
    LVBL = 1'b0;
    wait_cen();
    check_val("t1_req_after_vb", busrq_n, 0);
    wait_busy("t1_done", 1'b0, 2000);
    check_xfer("t1", 1);
    check_val("t1_busrq_rel", busrq_n, 1);
    check_val("t1_wrap", wrap_seen, 1);

    // Trigger inside VBLANK with an immediate bus grant.
    ak_delay = 0;
    fill_src(2);
    repeat (4) wait_cen();
    snap();
    dma_go = 1'b1;
    wait_cen();
    dma_go = 1'b0;
    check_val("t2_busy_set", busy, 1);
    check_val("t2_rq_cen1", busrq_n, 1);
    wait_cen();
    check_val("t2_rq_cen2", busrq_n, 0);
    wait_cen();
    wait_cen();
    check_val("t2_first_addr", src_addr, SB);
    check_val("t2_first_cs", src_cs, 1);
    check_val("t2_no_we_k0", obj_we, 0);
    wait_cen();
    check_val("t2_second_addr", src_addr, SB + 12'd1);
    check_val("t2_first_we", obj_we, 1);
    check_val("t2_first_oaddr", obj_addr, 0);
    check_val("t2_first_data", obj_dout, src_mem[SB]);
    wait_busy("t2_done", 1'b0, 2000);
    check_xfer("t2", 1);
    check_val("t2_ownership", own_cnt - own_b, N + 2);

    // Re-triggers mid-copy: one is queued, the next is dropped.
    fill_src(3);
    snap();
    pulse_go();
    wait_writes("t3_k200", 200, 2000);
    pulse_go();
    wait_writes("t3_k300", 300, 2000);
    pulse_go();
    wait_writes("t3_two", 2 * N, 4000);
    wait_busy("t3_done", 1'b0, 2000);
    repeat (50) wait_cen();
    check_xfer("t3", 2);
    check_val("t3_xfers", busy_rises - rise_b, 2);

    // CPU reclaims the bus for 10 cen mid-copy.
    fill_src(4);
    snap();
    pulse_go();
    wait_writes("t4_k100", 100, 2000);
    ak_force = 1'b1;
    wait_cen();
    in_gap = 1'b1;
    repeat (9) wait_cen();
    check_val("t4_gap_busy", busy, 1);
    @(posedge clk);
    #1;
    ak_force = 1'b0;
    in_gap = 1'b0;
    wait_busy("t4_done", 1'b0, 2000);
    check_xfer("t4", 1);
    check_val("t4_gap_writes", gap_wr - gap_b, 0);

    // Reset mid-copy, then a fresh complete transfer.
    fill_src(5);
    snap();
    pulse_go();
    wait_writes("t5_k50", 50, 2000);
    #2;
    rst = 1'b1;
    #1;
    check_val("t5_rst_busrq_n", busrq_n, 1);
    check_val("t5_rst_busy", busy, 0);
    check_val("t5_rst_obj_we", obj_we, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_val("t5_rst_src_addr", src_addr, SB);
    check_val("t5_rst_src_cs", src_cs, 0);
    fill_src(6);
    wait_cen();
    snap();
    pulse_go();
    wait_busy("t5_start", 1'b1, 50);
    wait_busy("t5_done", 1'b0, 2000);
    check_xfer("t5", 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
